shifter_iter: RTL and testbench
===============================

Name: shifter_iter

Overview:
- Parametrised multi-cycle barrel/iterative shifter for the execute stage. Successor to the fixed 16-bit left shifter.
- Supports WIDTH-bit data and four modes: SLL, SRL, SRA and ROR.
- Shifts by at most STEP bit positions per clock. Uses a valid/ready handshake on input and output.
- Processes one operation at a time. Any stall is visible through in_ready and out_valid.

Parameters:
- WIDTH, 16: data width. Power of 2, 4..64.
- STEP, 4: maximum shift distance applied per clock, 1..WIDTH-1.
- SHAMT_W, $clog2(WIDTH): shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHAMT_W  shift amount, 0..WIDTH-1.
- in_mode  in  2  operation select: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- abort  in  1  synchronous cancel.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.
- out_zero  out  1  only with SHIFT_FLAGS_EN.
- out_carry  out  1  only with SHIFT_FLAGS_EN.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; in_ready=0 while rst_n is low; out_valid=0; out_data=0; flags=0; internal registers cleared.
  - Any in-flight operation is discarded; no output is produced for it.
- FSM states: IDLE, SHIFT, DONE. in_ready=1 only in IDLE with rst_n high. out_valid=1 only in DONE.
- IDLE: on an edge with in_valid && in_ready, latch data, mode and rem=in_shamt.
  - Latch sign = in_data[WIDTH-1] for SRA fill.
  - If in_shamt==0, go to DONE; otherwise go to SHIFT.
- SHIFT: each edge shifts the working register by s=min(rem,STEP) in the latched mode, then rem -= s.
  - When rem becomes 0, go to DONE.
  - Fill rules: SLL and SRL fill with zeros; SRA fills with the latched sign; ROR feeds bits from LSB to MSB.
- Latency: out_valid rises after the accepting edge plus ceil(shamt/STEP) further edges.
  - shamt=0: out_valid is high in the cycle immediately after the accepting edge.
- DONE: out_data is held stable while out_valid=1 and out_ready=0, for any duration.
  - On an edge with out_ready=1, go to IDLE and drop out_valid.
  - No new input is accepted in the same edge; back-to-back throughput is one operation per ceil(shamt/STEP)+2 cycles.
- abort: sampled every edge and takes priority over all other events.
  - From SHIFT or DONE, go to IDLE next edge with out_valid=0.
  - In IDLE, an abort in the same cycle as in_valid suppresses acceptance.
- out_data keeps its last value outside DONE; consumers qualify it with out_valid only.
- Arithmetic: the result equals the single-step reference shift. Result width is WIDTH; bits shifted out are dropped.
- in_mode and in_shamt are ignored except on the accepting edge.

Optional Feature:
- Macro: SHIFT_FLAGS_EN.
- When defined, out_zero and out_carry are present and registered. Both are valid with out_valid and reset to 0.
  - out_zero = (result==0).
  - out_carry = last bit shifted out:
    - SLL: in_data[WIDTH-shamt].
    - SRL and SRA: in_data[shamt-1].
    - ROR: result[WIDTH-1].
    - shamt=0: 0.
  - The flags are computed incrementally during SHIFT; no extra latency is added.
- When not defined, the ports and their logic are absent, and area and timing match the base block.

Test Plan:
All scenarios use WIDTH=16, STEP=4.
- SLL 0x00FF, shamt 9 -> out_data 0xFE00; out_valid rises 3 edges after accept.
- SRA 0x8000, shamt 15 -> 0xFFFF after 4 edges. SRL 0x8001, shamt 15 -> 0x0001.
- ROR 0x1234, shamt 4 -> 0x4123 after 1 edge. ROR 0x0001, shamt 1 -> 0x8000.
- SLL 0xABCD, shamt 0 -> 0xABCD in the cycle after accept.
  - Hold out_ready=0 for 5 cycles -> out_data stable, in_ready=0 throughout.
  - Then out_ready=1 -> IDLE; in_ready=1 the next cycle.
- Start SRL 0xFFFF, shamt 12, then assert abort in the 2nd SHIFT cycle -> IDLE, no out_valid pulse.
  - Repeat the same operation with rst_n pulsed low mid-SHIFT -> all outputs 0 immediately.
  - Then run SLL 0x0001, shamt 3 -> 0x0008.
- SHIFT_FLAGS_EN: SLL 0x8000, shamt 1 -> out_data 0x0000, out_zero=1, out_carry=1.
  - SRL 0x0006, shamt 2 -> 0x0001, out_zero=0, out_carry=1.

Source files
------------

// File: rtl/shifter_iter.sv
// shifter_iter: multi-cycle iterative shifter for the execute stage.
// Applies at most STEP bit positions of shift per clock in one of four
// modes (SLL, SRL, SRA, ROR). It processes one operation at a time and
// uses a valid/ready handshake on both sides.
//
// Optional feature: define SHIFT_FLAGS_EN to add the registered out_zero
// and out_carry flags.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake
//   in_data/in_shamt    operand and shift amount (0..WIDTH-1)
//   in_mode             00 SLL, 01 SRL, 10 SRA, 11 ROR
//   abort               synchronous cancel, highest priority
//   out_valid/out_ready result handshake
//   out_data            result, held while out_valid && !out_ready
//   out_zero/out_carry  result==0 / last bit shifted out (SHIFT_FLAGS_EN)
//
// state | meaning
// IDLE  | waiting for an operation, in_ready high
// SHIFT | working register shifted by min(rem,STEP) per edge
// DONE  | result presented on out_data, out_valid high
module shifter_iter #(
  parameter int WIDTH   = 16,
  parameter int STEP    = 4,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
`ifdef SHIFT_FLAGS_EN
  ,
  output logic               out_zero,
  output logic               out_carry
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SHAMT_W-1:0] STEP_L  = SHAMT_W'(STEP);
  localparam logic [SHAMT_W:0]   WIDTH_L = (SHAMT_W+1)'(WIDTH);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   step_res;
  logic [1:0]         mode;
  logic [SHAMT_W-1:0] rem;
  logic [SHAMT_W-1:0] s;
  logic [SHAMT_W:0]   s_comp;
  logic               sign;
  logic               accept;
  logic               last_step;

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign accept    = (state == IDLE) && in_valid && !abort;
  assign s         = (rem < STEP_L) ? rem : STEP_L;
  assign last_step = (rem == s);
  // Left part of the rotate; s==0 gives a shift by WIDTH, i.e. all zeros.
  assign s_comp    = WIDTH_L - {1'b0, s};

  always_comb begin
    step_res = work;
    case (mode)
      2'b00: step_res = work << s;
      2'b01: step_res = work >> s;
      2'b10: step_res = (work >> s) | (sign ? ~({WIDTH{1'b1}} >> s) : '0);
      2'b11: step_res = (work >> s) | (work << s_comp);
      default: step_res = work;
    endcase
  end

`ifdef SHIFT_FLAGS_EN
  // The last bit leaving during the final step is the last bit leaving
  // overall, so the carry needs only the final step's view of work.
  localparam logic [SHAMT_W-1:0] ONE = SHAMT_W'(1);
  localparam logic [WIDTH-1:0]   MSB = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]   LSB = {{(WIDTH-1){1'b0}}, 1'b1};
  logic step_carry;

  always_comb begin
    step_carry = 1'b0;
    case (mode)
      2'b00:        step_carry = |(work & (MSB >> (s - ONE)));
      2'b01, 2'b10: step_carry = |(work & (LSB << (s - ONE)));
      default:      step_carry = step_res[WIDTH-1];
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (in_shamt == '0) ? DONE : SHIFT;
      SHIFT:   if (abort) state_nxt = IDLE;
               else if (last_step) state_nxt = DONE;
      DONE:    if (abort || out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work      <= '0;
      mode      <= '0;
      rem       <= '0;
      sign      <= 1'b0;
      out_data  <= '0;
`ifdef SHIFT_FLAGS_EN
      out_zero  <= 1'b0;
      out_carry <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          work <= in_data;
          mode <= in_mode;
          rem  <= in_shamt;
          sign <= in_data[WIDTH-1];
          if (in_shamt == '0) begin
            out_data  <= in_data;
`ifdef SHIFT_FLAGS_EN
            out_zero  <= (in_data == '0);
            out_carry <= 1'b0;
`endif
          end
        end
        SHIFT: if (!abort) begin
          work <= step_res;
          rem  <= rem - s;
          if (last_step) begin
            out_data  <= step_res;
`ifdef SHIFT_FLAGS_EN
            out_zero  <= (step_res == '0);
            out_carry <= step_carry;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_iter.sv
module tb_shifter_iter;
  localparam int WIDTH   = 16;
  localparam int STEP    = 4;
  localparam int SHAMT_W = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_mode;
  logic               abort;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
`ifdef SHIFT_FLAGS_EN
  logic               out_zero;
  logic               out_carry;
`endif

  int vectors = 0;
  int miscompares = 0;

  shifter_iter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
    .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef SHIFT_FLAGS_EN
    , .out_zero(out_zero), .out_carry(out_carry)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-shift reference: the full distance applied in one go.
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input int sh, input logic [1:0] m);
    logic [15:0] r;
    case (m)
      2'b00:   r = d << sh;
      2'b01:   r = d >> sh;
      2'b10:   r = 16'($signed(d) >>> sh);
      default: r = (sh == 0) ? d : ((d >> sh) | (d << (16 - sh)));
    endcase
    return r;
  endfunction

  function automatic logic ref_carry(input logic [15:0] d, input int sh, input logic [1:0] m);
    logic [15:0] r;
    if (sh == 0) return 1'b0;
    r = ref_shift(d, sh, m);
    case (m)
      2'b00:   return d[16 - sh];
      2'b11:   return r[15];
      default: return d[sh - 1];
    endcase
  endfunction

  task automatic run_op(input logic [15:0] d, input int sh, input logic [1:0] m, input int hold);
    logic [15:0] exp;
    int lat;
    int cnt;
    exp = ref_shift(d, sh, m);
    lat = (sh + STEP - 1) / STEP;
    @(negedge clk);
    check("ready_before_accept", in_ready, 1);
    in_valid = 1'b1; in_data = d; in_shamt = SHAMT_W'(sh); in_mode = m;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_mode  = 2'($urandom);
    in_shamt = SHAMT_W'($urandom);
    in_data  = 16'($urandom);
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("latency", cnt, lat);
    check("out_data", out_data, exp);
    check("ready_low_in_done", in_ready, 0);
`ifdef SHIFT_FLAGS_EN
    check("out_zero", out_zero, (exp == 16'h0));
    check("out_carry", out_carry, ref_carry(d, sh, m));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, exp);
      check("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    check("ready_return", in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0;
    abort = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h00FF, 9, 2'b00, 0);
    run_op(16'h8000, 15, 2'b10, 0);
    run_op(16'h8001, 15, 2'b01, 0);
    run_op(16'h1234, 4, 2'b11, 0);
    run_op(16'h0001, 1, 2'b11, 0);
    run_op(16'hABCD, 0, 2'b00, 5);
    run_op(16'h8000, 1, 2'b00, 0);
    run_op(16'h0006, 2, 2'b01, 0);

    // abort in the second SHIFT cycle
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'hFFFF; in_shamt = 4'd12; in_mode = 2'b01;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_pulse", out_valid, 0);
    end

    // abort with in_valid in IDLE suppresses acceptance
    in_valid = 1'b1; abort = 1'b1; in_data = 16'h0F0F; in_shamt = 4'd0;
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    check("abort_idle_noaccept", out_valid, 0);
    check("abort_idle_ready", in_ready, 1);

    // reset pulsed mid-SHIFT
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'hFFFF; in_shamt = 4'd12; in_mode = 2'b01;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    check("midrst_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_pulse", out_valid, 0);
    end
    run_op(16'h0001, 3, 2'b00, 0);

    for (int i = 0; i < 40; i++)
      run_op(16'($urandom), int'($urandom_range(0, 15)), 2'($urandom), int'($urandom_range(0, 2)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
